tcam_sram_search_engine: RTL
============================

// Module: tcam_sram_search_engine
// PURPOSE
//  Parametrised, pipelined SRAM-style TCAM. The query key is split into NUM_VTB slices of SUB_W bits.
//  Each slice indexes its own virtual TCAM block (VTB): a 2^SUB_W-row x ENTRIES-bit table.
//  The rows read from all VTBs are ANDed and priority-encoded into a match address.
//  Adds a hardware flush FSM and a registered 2-stage search pipeline. Sits between the host
//  request port and the packet-classification logic.
// PARAMETERS
//  ADDR_W   28  query key width; must equal NUM_VTB*SUB_W
//  SUB_W    7   key bits per VTB; each VTB has 2^SUB_W rows
//  NUM_VTB  4   number of virtual TCAM blocks (>=2)
//  ENTRIES  32  TCAM entries = row width in bits; multiple of 8, 8..64
//  PMA_W    $clog2(ENTRIES)+1  width of out_pma (derived, localparam)
// PORTS
//  in_clk     in   1                clock, all flops rise-edge
//  in_rst     in   1                async active-high reset
//  in_csb     in   1                active-low chip select; 1 = no operation
//  in_web     in   1                active-low write enable; 1 = search, 0 = write
//  in_wmask   in   ENTRIES/8        per-byte write enable for in_wdata
//  in_addr    in   ADDR_W           search key (in_web=1) or write address (in_web=0)
//  in_wdata   in   ENTRIES          row data for writes
//  in_flush   in   1                pulse: clear all VTB rows
//  out_busy   out  1                1 while flushing; requests dropped
//  out_valid  out  1                one-cycle pulse: out_pma/out_hit are new
//  out_hit    out  1                at least one entry matched
//  out_pma    out  PMA_W            priority match address: lowest matching index+1; 0 = miss
// BEHAVIOUR
//  Slicing: VTB i (i=0..NUM_VTB-1) uses key bits [ADDR_W-1-i*SUB_W -: SUB_W]; VTB0 takes the MSBs.
//  Write addressing: row = in_addr[SUB_W-1:0]; VTB select = in_addr[SUB_W +: $clog2(NUM_VTB)];
//    other bits ignored. VTB select >= NUM_VTB -> write dropped, no state change.
//  Write (csb=0, web=0, busy=0): byte b of the row updates at this edge iff in_wmask[b]=1.
//  Search (csb=0, web=1, busy=0) accepted at edge N:
//    S1: registers the row read from each VTB.
//    S2 (edge N+1): AND of all rows -> priority encode, registered.
//    out_valid=1 in cycle N+2. One search per cycle, fully pipelined.
//  Hazard: search issued in the cycle after a write sees the written data (write-first, no stall).
//  out_hit/out_pma hold their last value until the next out_valid.
//  Flush FSM states IDLE, FLUSH:
//    IDLE->FLUSH on in_flush=1; in_flush takes priority over a same-cycle csb=0 operation,
//      which is dropped.
//    FLUSH: row counter 0..2^SUB_W-1; each cycle zeroes that row in all VTBs in parallel.
//      At the last row -> IDLE. Duration is exactly 2^SUB_W cycles.
//    out_busy=1 in FLUSH. in_flush in FLUSH is ignored (no restart).
//  In-flight searches (already in S1/S2) when a flush starts complete normally with pre-flush data.
//  Reset (async): state=FLUSH, counter=0, pipeline valids=0; out_valid=0, out_hit=0, out_pma=0,
//    out_busy=1. The table is therefore all-zero 2^SUB_W cycles after reset release.
//    Reset asserted mid-flush restarts the flush from row 0.
//  All-zero rows mean no entry matches, so a search after a flush returns out_hit=0, out_pma=0.
// CONFIGURATION
//  TCAM_MULTI_HIT_EN defined: adds ports out_multi (1) and out_hit_cnt ($clog2(ENTRIES)+1).
//    Both are registered alongside out_pma: out_multi = popcount(match)>1;
//    out_hit_cnt = popcount(match). Reset 0.
//  Not defined: neither port exists, no popcount logic; all else identical.
// TESTING
//  Default params used throughout.
//  Reset release -> out_busy=1 for exactly 128 cycles, then 0; any search -> out_valid at +2,
//    out_hit=0, out_pma=0.
//  Key Q=28'h1234567: write bit 5 (wmask=4'b0001, wdata=32'h20) at each VTB's slice row.
//    Search Q -> out_pma=6, out_hit=1 at +2 cycles.
//  Also set bit 2 in all four Q rows. Search Q -> out_pma=3. With TCAM_MULTI_HIT_EN:
//    out_multi=1, out_hit_cnt=2.
//  Back-to-back searches Q, Q', Q (Q' unmatched) -> out_valid on 3 consecutive cycles,
//    out_pma 3, 0, 3.
//  Write a row, then search it the next cycle -> the result reflects the new data.
//  Write with wmask=4'b0000 -> no change.
//  in_flush with a search in S1 -> that search still returns 3; during the next 128 cycles requests
//    are dropped (no out_valid). After the flush, search Q -> out_pma=0.
//  Assert in_rst at flush row 60 -> flush restarts; out_busy stays 1 for 128 cycles after release.

Source files
------------

// File: rtl/tcam_sram_search_engine.sv
// SRAM-style TCAM: key slices index per-slice row tables, rows are ANDed and priority encoded.
// Define TCAM_MULTI_HIT_EN to add the out_multi / out_hit_cnt popcount outputs.
module tcam_sram_search_engine #(
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned SUB_W   = 7,
    parameter int unsigned NUM_VTB = 4,
    parameter int unsigned ENTRIES = 32,
    localparam int unsigned PMA_W  = $clog2(ENTRIES) + 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_csb,
    input  logic                 in_web,
    input  logic [ENTRIES/8-1:0] in_wmask,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [ENTRIES-1:0]   in_wdata,
    input  logic                 in_flush,
    output logic                 out_busy,
    output logic                 out_valid,
    output logic                 out_hit,
    output logic [PMA_W-1:0]     out_pma
`ifdef TCAM_MULTI_HIT_EN
    ,
    output logic                 out_multi,
    output logic [PMA_W-1:0]     out_hit_cnt
`endif
);

    localparam int unsigned ROWS   = 2 ** SUB_W;
    localparam int unsigned BYTES  = ENTRIES / 8;
    localparam int unsigned VSEL_W = (NUM_VTB > 1) ? $clog2(NUM_VTB) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [SUB_W-1:0]     flush_row, flush_row_nxt;
    logic                 busy_nxt;

    logic [ENTRIES-1:0]   mem [NUM_VTB][ROWS];
    logic [ENTRIES-1:0]   s1_rows [NUM_VTB];
    logic                 s1_valid;

    logic                 req_ok_c, wr_en_c, srch_en_c;
    logic [VSEL_W-1:0]    wr_vtb_c;
    logic [SUB_W-1:0]     wr_row_c;
    logic [NUM_VTB-1:0]   wr_oh_c;
    logic [ENTRIES-1:0]   match_c;
    logic                 hit_c;
    logic [PMA_W-1:0]     pma_c;
`ifdef TCAM_MULTI_HIT_EN
    logic [PMA_W-1:0]     cnt_c;
`endif

    // Request qualification; a flush pulse wins over a same-cycle request
    assign req_ok_c  = (state == IDLE) && !in_flush && !in_csb;
    assign srch_en_c = req_ok_c && in_web;
    assign wr_vtb_c  = in_addr[SUB_W +: VSEL_W];
    assign wr_row_c  = in_addr[SUB_W-1:0];
    assign wr_en_c   = req_ok_c && !in_web && (|wr_oh_c);

    // One-hot VTB decode; an out-of-range select decodes to nothing
    always_comb begin
        wr_oh_c = '0;
        for (int v = 0; v < NUM_VTB; v++) begin
            if (wr_vtb_c == VSEL_W'(v)) wr_oh_c[v] = 1'b1;
        end
    end

    // Flush FSM next state
    always_comb begin
        state_nxt     = state;
        flush_row_nxt = flush_row;
        case (state)
            IDLE: begin
                if (in_flush) begin
                    state_nxt     = FLUSH;
                    flush_row_nxt = '0;
                end
            end
            FLUSH: begin
                flush_row_nxt = flush_row + 1'b1;
                if (flush_row == SUB_W'(ROWS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = FLUSH;
        endcase
        busy_nxt = (state_nxt == FLUSH);
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state     <= FLUSH;
            flush_row <= '0;
            out_busy  <= 1'b1;
        end else begin
            state     <= state_nxt;
            flush_row <= flush_row_nxt;
            out_busy  <= busy_nxt;
        end
    end

    // Row storage: flush zeroes one row per cycle in every VTB, else byte-masked writes
    always_ff @(posedge in_clk) begin
        for (int v = 0; v < NUM_VTB; v++) begin
            if (state == FLUSH) begin
                mem[v][flush_row] <= '0;
            end else if (wr_en_c && wr_oh_c[v]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (in_wmask[b]) mem[v][wr_row_c][b*8 +: 8] <= in_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 1: capture the row each key slice selects; VTB0 takes the MSB slice
    always_ff @(posedge in_clk) begin
        if (srch_en_c) begin
            for (int v = 0; v < NUM_VTB; v++) begin
                s1_rows[v] <= mem[v][in_addr[ADDR_W-1-v*SUB_W -: SUB_W]];
            end
        end
    end

    // Stage 2 combine: AND rows, lowest set bit wins
    always_comb begin
        match_c = '1;
        for (int v = 0; v < NUM_VTB; v++) match_c = match_c & s1_rows[v];
        hit_c = |match_c;
        pma_c = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_c[i]) pma_c = PMA_W'(i + 1);
        end
`ifdef TCAM_MULTI_HIT_EN
        cnt_c = '0;
        for (int i = 0; i < ENTRIES; i++) cnt_c = cnt_c + PMA_W'(match_c[i]);
`endif
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            s1_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_hit     <= 1'b0;
            out_pma     <= '0;
`ifdef TCAM_MULTI_HIT_EN
            out_multi   <= 1'b0;
            out_hit_cnt <= '0;
`endif
        end else begin
            s1_valid  <= srch_en_c;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_hit     <= hit_c;
                out_pma     <= pma_c;
`ifdef TCAM_MULTI_HIT_EN
                out_multi   <= (cnt_c > PMA_W'(1));
                out_hit_cnt <= cnt_c;
`endif
            end
        end
    end

endmodule
